// File: rtl/gather_datas_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gather_datas_serializer_pkg
//  Description : Shared definitions for the gather serializer: control-state
//                encodings and the ceiling-log2 helper used to size the slot
//                index from the slot count.
//  Revision    : 1.0 - initial release
// ============================================================================
package gather_datas_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    // Smallest r such that 2**r >= n (elaboration-time use only).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v << 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage : gather_datas_serializer_pkg
`default_nettype wire

// File: rtl/gather_datas_serializer_lowest_one_index.sv
`default_nettype none
// ============================================================================
//  Module      : lowest_one_index
//  Description : Combinational priority encoder returning the index of the
//                lowest set bit of a NUM-bit vector. Built as a recursive
//                halving tree: each level picks the low half if it has any
//                set bit, otherwise the high half, prefixing one index bit.
//  Ports       : pend [NUM]   - vector to search
//                idx  [IDX_W] - index of the lowest set bit (meaningful
//                               only when any = 1)
//                any          - at least one bit of pend is set
//  Revision    : 1.0 - initial release
// ============================================================================
module lowest_one_index #(
    parameter int NUM   = 8,
    parameter int IDX_W = 3
) (
    input  logic [NUM-1:0]   pend,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    generate
        if (NUM == 2) begin : g_leaf
            // Two-bit leaf: IDX_W is 1 here.
            assign any = pend[0] | pend[1];
            assign idx = pend[0] ? '0 : '1;
        end else begin : g_split
            localparam int HALF = NUM / 2;

            logic [IDX_W-2:0] w_lo_idx;
            logic [IDX_W-2:0] w_hi_idx;
            logic             w_lo_any;
            logic             w_hi_any;

            lowest_one_index #(
                .NUM   (HALF),
                .IDX_W (IDX_W - 1)
            ) u_lo (
                .pend (pend[HALF-1:0]),
                .idx  (w_lo_idx),
                .any  (w_lo_any)
            );

            lowest_one_index #(
                .NUM   (HALF),
                .IDX_W (IDX_W - 1)
            ) u_hi (
                .pend (pend[NUM-1:HALF]),
                .idx  (w_hi_idx),
                .any  (w_hi_any)
            );

            // Low half wins whenever it has a set bit.
            assign any = w_lo_any | w_hi_any;
            assign idx = w_lo_any ? {1'b0, w_lo_idx} : {1'b1, w_hi_idx};
        end
    endgenerate

endmodule : lowest_one_index
`default_nettype wire

// File: rtl/gather_datas_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : gather_datas_serializer
//  Description : Captures a packed vector of NUM slot values plus a select
//                mask, then emits the selected slots one per valid/ready
//                handshake in ascending index order as (index, data) pairs.
//                A one-cycle done pulse follows the last accepted item, or
//                directly follows a load with an empty mask.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                start_i             - load request (sampled in IDLE only)
//                rd_mask_i [NUM]     - slots to emit
//                data_i [NUM*WIDTH]  - packed slot values, slot 0 in LSBs
//                busy_o              - transfer in progress (SEND or DONE)
//                valid_o, ready_i    - output handshake
//                data_o [WIDTH]      - current slot value
//                idx_o [IDX_W]       - current slot index
//                done_o              - end-of-transfer pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module gather_datas_serializer
    import gather_datas_serializer_pkg::*;
#(
    parameter int NUM   = 8,
    parameter int WIDTH = 5,
    parameter int IDX_W = clog2(NUM)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [NUM-1:0]       rd_mask_i,
    input  logic [NUM*WIDTH-1:0] data_i,
    output logic                 busy_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [WIDTH-1:0]     data_o,
    output logic [IDX_W-1:0]     idx_o,
    output logic                 done_o
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [NUM*WIDTH-1:0] r_data_reg;
    logic [NUM*WIDTH-1:0] w_data_nxt;
    logic [NUM-1:0]       r_pend;
    logic [NUM-1:0]       w_pend_nxt;
    logic [NUM-1:0]       w_onehot;
    logic [NUM-1:0]       w_pend_cleared;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_any;
    logic                 w_send;
    logic [WIDTH-1:0]     w_slot [NUM];

    lowest_one_index #(
        .NUM   (NUM),
        .IDX_W (IDX_W)
    ) u_lowest_one_index (
        .pend (r_pend),
        .idx  (w_idx),
        .any  (w_any)
    );

    // Unpack the captured vector so the output mux is a plain array index.
    generate
        for (genvar i = 0; i < NUM; i++) begin : g_slot
            assign w_slot[i] = r_data_reg[i*WIDTH +: WIDTH];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State and capture registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_data_reg <= '0;
            r_pend     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_data_reg <= w_data_nxt;
            r_pend     <= w_pend_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt          = r_state;
        w_data_nxt           = r_data_reg;
        w_pend_nxt           = r_pend;
        w_onehot             = '0;
        w_onehot[w_idx]      = 1'b1;
        w_pend_cleared       = r_pend & ~w_onehot;

        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_data_nxt  = data_i;
                    w_pend_nxt  = rd_mask_i;
                    w_state_nxt = (rd_mask_i != '0) ? SEND : DONE;
                end
            end
            SEND: begin
                if (ready_i) begin
                    w_pend_nxt = w_pend_cleared;
                    if (w_pend_cleared == '0) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs, decoded from registered state only. pend is never empty in
    // SEND, so qualifying with w_any does not change behaviour; it only
    // guarantees valid_o can never present a stale index.
    // ------------------------------------------------------------------------
    assign w_send  = (r_state == SEND) && w_any;
    assign valid_o = w_send;
    assign busy_o  = (r_state == SEND) || (r_state == DONE);
    assign done_o  = (r_state == DONE);
    assign idx_o   = w_send ? w_idx : '0;
    assign data_o  = w_send ? w_slot[w_idx] : '0;

endmodule : gather_datas_serializer
`default_nettype wire

// File: tb/tb_gather_datas_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gather_datas_serializer
//  Description : Self-checking bench for gather_datas_serializer. A queue
//                model of pending (index, data) items predicts every output
//                on every cycle; directed scenarios pin the model with
//                hand-computed literals, then a randomized phase follows.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gather_datas_serializer;

    localparam int NUM   = 8;
    localparam int WIDTH = 5;
    localparam int IDX_W = 3;

    logic                 clk       = 1'b0;
    logic                 rst_n     = 1'b0;
    logic                 start_i   = 1'b0;
    logic                 ready_i   = 1'b0;
    logic [NUM-1:0]       rd_mask_i = '0;
    logic [NUM*WIDTH-1:0] data_i    = '0;
    logic                 busy_o;
    logic                 valid_o;
    logic [WIDTH-1:0]     data_o;
    logic [IDX_W-1:0]     idx_o;
    logic                 done_o;

    gather_datas_serializer #(
        .NUM   (NUM),
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start_i),
        .rd_mask_i (rd_mask_i),
        .data_i    (data_i),
        .busy_o    (busy_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .data_o    (data_o),
        .idx_o     (idx_o),
        .done_o    (done_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model: the items still to emit, in order, plus a flag for
    // the done cycle. Empty queue and no done flag means idle.
    // ------------------------------------------------------------------------
    typedef struct { int idx; int data; } item_t;
    item_t m_q[$];
    bit    m_done = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_done = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_q.size() > 0) begin
            if (ready_i) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_done = 1'b1;
            end
        end else if (start_i) begin
            for (int i = 0; i < NUM; i++) begin
                if (rd_mask_i[i]) m_q.push_back('{i, int'(data_i[i*WIDTH +: WIDTH])});
            end
            if (m_q.size() == 0) m_done = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Per-cycle compare and event logs (negedge, away from the active edge)
    // ------------------------------------------------------------------------
    typedef struct { int cyc; int idx; int data; } log_t;
    log_t acc_q[$];
    int   done_q[$];
    int   busy_cnt = 0;

    always @(negedge clk) begin
        bit exp_valid;
        exp_valid = (m_q.size() > 0);
        chk("valid_o", valid_o, exp_valid);
        chk("done_o",  done_o,  m_done);
        chk("busy_o",  busy_o,  exp_valid || m_done);
        chk("idx_o",   idx_o,   exp_valid ? m_q[0].idx  : 0);
        chk("data_o",  data_o,  exp_valid ? m_q[0].data : 0);
        if (valid_o && ready_i) acc_q.push_back('{cyc, int'(idx_o), int'(data_o)});
        if (done_o) done_q.push_back(cyc);
        if (busy_o) busy_cnt++;
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers: inputs change 2 time units after the rising edge.
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [NUM*WIDTH-1:0] rand_data();
        return (NUM*WIDTH)'({$urandom, $urandom});
    endfunction

    function automatic logic [NUM*WIDTH-1:0] seq_data();
        logic [NUM*WIDTH-1:0] d;
        for (int i = 0; i < NUM; i++) d[i*WIDTH +: WIDTH] = WIDTH'(i + 1);
        return d;
    endfunction

    // Returns the cycle number of the start_i cycle.
    task automatic start_load(input logic [NUM-1:0] mask, input logic [NUM*WIDTH-1:0] d,
                              output int s);
        s         = cyc;
        rd_mask_i = mask;
        data_i    = d;
        start_i   = 1'b1;
        tick();
        start_i   = 1'b0;
        rd_mask_i = NUM'($urandom);
        data_i    = rand_data();
    endtask

    task automatic wait_done(input int limit, output int dcyc);
        dcyc = -1;
        for (int k = 0; k < limit && dcyc < 0; k++) begin
            if (done_o) dcyc = cyc;
            else tick();
        end
        if (dcyc < 0) chk("done_timeout", 0, 1);
    endtask

    task automatic clear_logs();
        acc_q.delete();
        done_q.delete();
        busy_cnt = 0;
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        int s, s2, d;
        logic [NUM*WIDTH-1:0] dv;

        // Reset state
        rst_n = 1'b0;
        tick();
        chk("rst_valid", valid_o, 0);
        chk("rst_busy",  busy_o,  0);
        chk("rst_done",  done_o,  0);
        chk("rst_idx",   idx_o,   0);
        chk("rst_data",  data_o,  0);
        tick();
        rst_n = 1'b1;
        tick();

        // 1. Reset mid-SEND after three items
        clear_logs();
        ready_i = 1'b1;
        start_load(8'hFF, seq_data(), s);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("t1_valid_async", valid_o, 0);
        chk("t1_busy_async",  busy_o,  0);
        chk("t1_items_before_rst", acc_q.size(), 3);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("t1_no_done", done_q.size(), 0);
        chk("t1_idle_busy", busy_o, 0);

        // 2. Full drain, ready held high
        clear_logs();
        start_load(8'hFF, seq_data(), s);
        wait_done(20, d);
        chk("t2_done_latency", d - s, 9);
        tick();
        chk("t2_busy_low", busy_o, 0);
        chk("t2_items", acc_q.size(), 8);
        chk("t2_done_count", done_q.size(), 1);
        for (int k = 0; k < 8 && k < acc_q.size(); k++) begin
            chk("t2_idx",  acc_q[k].idx,  k);
            chk("t2_data", acc_q[k].data, k + 1);
            chk("t2_cyc",  acc_q[k].cyc - s, k + 1);
        end

        // 3. Sparse mask with backpressure
        clear_logs();
        ready_i = 1'b0;
        dv = rand_data();
        dv[2*WIDTH +: WIDTH] = 5'h1F;
        dv[5*WIDTH +: WIDTH] = 5'h0A;
        dv[7*WIDTH +: WIDTH] = 5'h11;
        start_load(8'b1010_0100, dv, s);
        for (int k = 0; k < 3; k++) begin
            tick();
            tick();
            ready_i = 1'b1;
            tick();
            ready_i = 1'b0;
        end
        wait_done(10, d);
        tick();
        chk("t3_items", acc_q.size(), 3);
        chk("t3_done_count", done_q.size(), 1);
        if (acc_q.size() == 3) begin
            chk("t3_idx0", acc_q[0].idx, 2);  chk("t3_data0", acc_q[0].data, 'h1F);
            chk("t3_idx1", acc_q[1].idx, 5);  chk("t3_data1", acc_q[1].data, 'h0A);
            chk("t3_idx2", acc_q[2].idx, 7);  chk("t3_data2", acc_q[2].data, 'h11);
        end

        // 4. Empty mask
        clear_logs();
        start_load('0, rand_data(), s);
        wait_done(5, d);
        chk("t4_done_latency", d - s, 1);
        tick();
        tick();
        chk("t4_busy_cycles", busy_cnt, 1);
        chk("t4_no_items", acc_q.size(), 0);
        chk("t4_done_count", done_q.size(), 1);

        // 5. Ignored start during SEND, then back-to-back load
        clear_logs();
        ready_i = 1'b1;
        dv = rand_data();
        start_load(8'hFF, dv, s);
        tick();
        start_i   = 1'b1;
        rd_mask_i = 8'h0F;
        data_i    = rand_data();
        tick();
        start_i   = 1'b0;
        wait_done(20, d);
        chk("t5_done_latency", d - s, 9);
        chk("t5_items", acc_q.size(), 8);
        for (int k = 0; k < 8 && k < acc_q.size(); k++) begin
            chk("t5_idx",  acc_q[k].idx,  k);
            chk("t5_data", acc_q[k].data, int'(dv[k*WIDTH +: WIDTH]));
        end
        tick();
        chk("t5_idle_busy", busy_o, 0);
        start_load(8'h41, seq_data(), s2);
        chk("t5_b2b_valid", valid_o, 1);
        chk("t5_b2b_idx",   idx_o,   0);
        chk("t5_b2b_data",  data_o,  1);
        wait_done(10, d);
        chk("t5_b2b_latency", d - s2, 3);
        tick();

        // Randomized phase
        for (int n = 0; n < 3000; n++) begin
            start_i   = ($urandom % 5 == 0);
            rd_mask_i = ($urandom % 8 == 0) ? '0 : NUM'($urandom);
            data_i    = rand_data();
            ready_i   = ($urandom % 4 != 0);
            if ($urandom % 400 == 0) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end else begin
                tick();
            end
        end
        start_i = 1'b0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule : tb_gather_datas_serializer
`default_nettype wire
